// File: rtl/qu_prog_loader.sv
// qu_prog_loader: boot-time program loader for the Qu core.
// Receives a byte stream made of a 4-byte little-endian word count followed by
// the instruction words (little-endian). It writes each word to the program
// port and holds the core stalled until the whole image has been accepted.
// Optional feature: define QU_PROG_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte over all data bytes before the core is released.
// Handshake: a byte moves only on a cycle where rx_valid && rx_ready at the
// rising clock edge. rx_valid may drop at any time. rx_ready depends only on
// the current state.
module qu_prog_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_stall,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
`ifdef QU_PROG_LOADER_CHECKSUM_EN
        ,
        S_CHK   = 3'd6
`endif
    } state_t;

    // State entered once every word has been written (or the count was zero).
`ifdef QU_PROG_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CHK;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    // Largest image that still fits between BASE_ADDR and the top of memory.
    localparam logic [32:0]           MAX_WORDS = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  byte_cnt;
    logic [31:0] count;
    logic [23:0] word_reg;
    logic        accept;
    logic        load_start;
    logic        last_byte;
    logic        last_word;
    logic [31:0] count_full;
`ifdef QU_PROG_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign accept     = rx_valid && rx_ready;
    assign last_byte  = (byte_cnt == 2'd3);
    assign count_full = {rx_data, count[31:8]};
    assign last_word  = ({{(31 - ADDR_WIDTH){1'b0}}, words_loaded} + 32'd1) == count;
    assign load_start = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt  = state;
        rx_ready   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 4'h0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        core_stall = 1'b1;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LEN;
            end
            S_LEN: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept && last_byte) begin
                    if (count_full == 32'd0)                    state_nxt = S_FIN;
                    else if ({1'b0, count_full} > MAX_WORDS)    state_nxt = S_ERR;
                    else                                        state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept && last_byte) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_en    = 1'b1;
                mem_we    = 4'hF;
                busy      = 1'b1;
                state_nxt = last_word ? S_FIN : S_DATA;
            end
`ifdef QU_PROG_LOADER_CHECKSUM_EN
            S_CHK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept) state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: begin
                done       = 1'b1;
                core_stall = 1'b0;
                if (start) state_nxt = S_LEN;
            end
            S_ERR: begin
                error = 1'b1;
                if (start) state_nxt = S_LEN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Byte assembly, word counter and memory address/data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt     <= 2'd0;
            count        <= 32'd0;
            word_reg     <= 24'd0;
            words_loaded <= '0;
            mem_addr     <= '0;
            mem_wdata    <= 32'd0;
`ifdef QU_PROG_LOADER_CHECKSUM_EN
            csum         <= 8'h00;
`endif
        end else if (load_start) begin
            byte_cnt     <= 2'd0;
            count        <= 32'd0;
            words_loaded <= '0;
`ifdef QU_PROG_LOADER_CHECKSUM_EN
            csum         <= 8'h00;
`endif
        end else begin
            if (state == S_LEN && accept) begin
                count    <= count_full;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == S_DATA && accept) begin
                word_reg <= {rx_data, word_reg[23:8]};
                byte_cnt <= byte_cnt + 2'd1;
`ifdef QU_PROG_LOADER_CHECKSUM_EN
                csum     <= csum ^ rx_data;
`endif
                // Address and data are staged here so they are valid during WRITE
                // and simply hold afterwards.
                if (last_byte) begin
                    mem_addr  <= BASE + words_loaded[ADDR_WIDTH-1:0];
                    mem_wdata <= {rx_data, word_reg};
                end
            end
            if (state == S_WRITE) words_loaded <= words_loaded + 1'b1;
        end
    end

endmodule

// File: tb/tb_qu_prog_loader.sv
// Testbench for qu_prog_loader: drives byte images and scores every memory
// write against an expected queue of {address, data} entries.
module tb_qu_prog_loader;
  localparam int AW   = 12;
  localparam int BASE = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_stall;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  qu_prog_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_stall(core_stall), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int strobe_cnt = 0;
  logic [AW+31:0] exp_q[$];
  logic [7:0] exp_csum;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe pops one expected {addr, data}
  always @(negedge clk) begin
    if (!rst && mem_en === 1'b1) begin
      logic [AW+31:0] e;
      strobe_cnt++;
      check_val("write_rx_ready_low", rx_ready, 0);
      check_val("write_we", mem_we, 4'hF);
      check_val("write_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("write_addr", mem_addr, e[AW+31:32]);
        check_val("write_data", mem_wdata, e[31:0]);
      end
    end
  end

  // driver tasks (all drives at #1 after the rising edge)
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc;
    acc = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = rx_ready;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    rx_data  = 8'($urandom_range(0, 255));
    check_val("byte_accepted", acc, 1);
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 30 && !(done || error); i++) begin
      @(posedge clk); #1;
    end
    check_val("end_reached", done | error, 1);
  endtask

  // one complete image; bad=1 corrupts the checksum byte (checksum builds only)
  task automatic load_image(input int n, input bit gap, input bit bad);
    logic [31:0] w;
    exp_csum = 8'h00;
    pulse_start();
    send_word(32'(n), gap);
    for (int i = 0; i < n; i++) begin
      w = (n == 1) ? 32'h12345678 : $urandom;
      exp_q.push_back({AW'(BASE + i), w});
      for (int k = 0; k < 4; k++) exp_csum ^= w[8*k +: 8];
      for (int k = 0; k < 3; k++) send_byte(w[8*k +: 8], gap);
      send_byte(w[31:24], 1'b0);
      check_val("write_latency", mem_en, 1);
      if (gap) begin
        @(posedge clk); #1;
        if (i == 0) pulse_start();
      end
    end
`ifdef QU_PROG_LOADER_CHECKSUM_EN
    send_byte(bad ? (exp_csum ^ 8'h08) : exp_csum, gap);
`else
    if (bad) $display("[TB] checksum corruption ignored in this build");
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_core_stall"}, core_stall, 1);
    check_val({tag, "_rx_ready"}, rx_ready, 0);
    check_val({tag, "_mem_en"}, mem_en, 0);
    check_val({tag, "_mem_we"}, mem_we, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_error"}, error, 0);
    check_val({tag, "_words_loaded"}, words_loaded, 0);
    check_val({tag, "_mem_addr"}, mem_addr, 0);
    check_val({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    int s0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1. reset state
    check_reset_values("reset");
    @(posedge clk); #1;

    // 2. single word image
    s0 = strobe_cnt;
    load_image(1, 1'b0, 1'b0);
    wait_end();
    check_val("t2_done", done, 1);
    check_val("t2_core_stall", core_stall, 0);
    check_val("t2_busy", busy, 0);
    check_val("t2_words_loaded", words_loaded, 1);
    check_val("t2_strobes", strobe_cnt - s0, 1);
    check_val("t2_hold_addr", mem_addr, BASE);
    check_val("t2_hold_data", mem_wdata, 32'h12345678);
    check_val("t2_queue_empty", exp_q.size(), 0);

    // 3. three words, rx_valid toggling, start ignored mid-load
    s0 = strobe_cnt;
    load_image(3, 1'b1, 1'b0);
    wait_end();
    check_val("t3_done", done, 1);
    check_val("t3_words_loaded", words_loaded, 3);
    check_val("t3_strobes", strobe_cnt - s0, 3);
    check_val("t3_queue_empty", exp_q.size(), 0);

    // 4a. empty image
    s0 = strobe_cnt;
    load_image(0, 1'b0, 1'b0);
    wait_end();
    check_val("t4_zero_done", done, 1);
    check_val("t4_zero_strobes", strobe_cnt - s0, 0);
    check_val("t4_zero_words", words_loaded, 0);

    // 4b. one word too many
    s0 = strobe_cnt;
    pulse_start();
    check_val("t4_restart_done_low", done, 0);
    check_val("t4_restart_stall", core_stall, 1);
    send_word(32'((1 << AW) - BASE + 1), 1'b0);
    wait_end();
    check_val("t4_err", error, 1);
    check_val("t4_err_stall", core_stall, 1);
    check_val("t4_err_busy", busy, 0);
    check_val("t4_err_done", done, 0);
    check_val("t4_err_strobes", strobe_cnt - s0, 0);

    // 4c. recovery after error
    load_image(2, 1'b0, 1'b0);
    wait_end();
    check_val("t4_recover_error", error, 0);
    check_val("t4_recover_done", done, 1);
    check_val("t4_recover_words", words_loaded, 2);

    // 5. largest legal count is accepted, then reset mid-word
    pulse_start();
    send_word(32'((1 << AW) - BASE), 1'b0);
    check_val("t5_max_count_error", error, 0);
    check_val("t5_max_count_busy", busy, 1);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h55, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_values("t5_abort");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    s0 = strobe_cnt;
    load_image(2, 1'b0, 1'b0);
    wait_end();
    check_val("t5_done", done, 1);
    check_val("t5_words", words_loaded, 2);
    check_val("t5_strobes", strobe_cnt - s0, 2);

`ifdef QU_PROG_LOADER_CHECKSUM_EN
    // 6. wrong checksum byte: word still written, load fails
    s0 = strobe_cnt;
    load_image(1, 1'b0, 1'b1);
    wait_end();
    check_val("t6_error", error, 1);
    check_val("t6_stall", core_stall, 1);
    check_val("t6_done", done, 0);
    check_val("t6_strobes", strobe_cnt - s0, 1);
`endif

    check_val("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
